seq_alu: RTL and testbench



---
 rtl/alu_pkg.sv | 42 ++++
 rtl/seq_alu_iter.sv | 108 ++++++++++
 rtl/seq_alu.sv | 188 ++++++++++++++++++
 tb/tb_seq_alu.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM encoding and
// the multi-cycle opcode classifier.
// Build option: define SEQ_ALU_DIV_EN to compile in the restoring divider.
package alu_pkg;

  // 4-bit opcode map inherited from the combinational alu
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_DIV = 4'b0110;
  localparam logic [3:0] OP_REM = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1001;
  localparam logic [3:0] OP_SHR = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;

  // Top-level handshake FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operation selector for the shared iterative datapath
  typedef enum logic [1:0] {
    IT_MUL = 2'd0,
    IT_DIV = 2'd1,
    IT_REM = 2'd2
  } iter_mode_t;

  // True for opcodes that run through the iterative datapath
  function automatic logic is_multicycle(input logic [3:0] op);
`ifdef SEQ_ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath shared by the shift-add multiplier and the restoring
// divider. One step per clock over a 2*WORD_SIZE accumulator; 'last' flags
// the cycle whose step completes the operation, and result/carry show the
// value the accumulator takes on that edge.
// Build option: SEQ_ALU_DIV_EN compiles in the divider step.
module seq_alu_iter
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = 64,
  localparam int SHAMT_W = $clog2(WORD_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  iter_mode_t           mode,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  output logic                 last,
  output logic [WORD_SIZE-1:0] result,
  output logic                 carry
);

  localparam int W     = WORD_SIZE;
  localparam int CNT_W = SHAMT_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_SIZE - 1);

  logic             run_reg;
  iter_mode_t       mode_reg;
  logic [W-1:0]     opb_reg;     // multiplicand (MUL) or divisor (DIV/REM)
  logic [2*W-1:0]   acc_reg;     // {high/remainder, low/quotient}
  logic [CNT_W-1:0] count_reg;

  logic [W:0]       mul_sum;
  logic [2*W-1:0]   mul_step;
  logic [2*W-1:0]   acc_step;

  // Shift-add: conditionally add the multiplicand into the high half,
  // then shift the whole accumulator right by one (carry-in at the top).
  always_comb begin
    mul_sum  = {1'b0, acc_reg[2*W-1:W]};
    if (acc_reg[0]) begin
      mul_sum = {1'b0, acc_reg[2*W-1:W]} + {1'b0, opb_reg};
    end
    mul_step = {mul_sum, acc_reg[W-1:1]};
  end

`ifdef SEQ_ALU_DIV_EN
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic           div_ge;
  logic [2*W-1:0] div_step;

  // Restoring step: shift the next dividend bit into the partial remainder,
  // trial-subtract the divisor, keep the difference only when it did not
  // borrow. The partial remainder is always below the divisor, so the top
  // bit of the difference is a clean borrow indicator.
  always_comb begin
    div_shift = {acc_reg[2*W-1:W], acc_reg[W-1]};
    div_diff  = div_shift - {1'b0, opb_reg};
    div_ge    = ~div_diff[W];
    div_step  = {(div_ge ? div_diff[W-1:0] : div_shift[W-1:0]),
                 acc_reg[W-2:0], div_ge};
  end
`endif

  // Select the step for the active operation and expose the finishing value
  always_comb begin
    acc_step = mul_step;
`ifdef SEQ_ALU_DIV_EN
    if (mode_reg != IT_MUL) begin
      acc_step = div_step;
    end
`endif
    result = (mode_reg == IT_REM) ? acc_step[2*W-1:W] : acc_step[W-1:0];
    carry  = (mode_reg == IT_MUL) ? (|acc_step[2*W-1:W]) : 1'b0;
  end

  assign last = run_reg && (count_reg == CNT_LAST);

  // Operand load on start, then one step per cycle until the counter hits WORD_SIZE
  always_ff @(posedge clk) begin
    if (rst) begin
      run_reg   <= 1'b0;
      mode_reg  <= IT_MUL;
      opb_reg   <= '0;
      acc_reg   <= '0;
      count_reg <= '0;
    end else if (start) begin
      run_reg   <= 1'b1;
      mode_reg  <= mode;
      count_reg <= '0;
      if (mode == IT_MUL) begin
        opb_reg <= a;
        acc_reg <= {{W{1'b0}}, b};
      end else begin
        opb_reg <= b;
        acc_reg <= {{W{1'b0}}, a};
      end
    end else if (run_reg) begin
      acc_reg   <= acc_step;
      count_reg <= count_reg + 1'b1;
      if (last) begin
        run_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes on both sides. Single-cycle
// ops complete on the accept edge; MUL (and DIV/REM when built in) go
// through seq_alu_iter. Results and flags are registered and held until
// the consumer takes them.
// Build option: define SEQ_ALU_DIV_EN to enable DIV/REM; otherwise those
// opcodes behave like any unassigned opcode (out = d1).
module seq_alu
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = 64,
  localparam int SHAMT_W = $clog2(WORD_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] d1,
  input  logic [WORD_SIZE-1:0] d2,
  input  logic [3:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out,
  output logic                 iszero,
  output logic                 iscarry
);

  localparam int W = WORD_SIZE;

  state_t       state_reg;
  logic [W-1:0] out_reg;
  logic         iszero_reg;
  logic         iscarry_reg;

  logic [SHAMT_W-1:0] shamt;
  logic [W:0]         add_sum;
  logic [W:0]         sub_sum;
  logic [W:0]         shl_wide;
  logic [W:0]         shr_wide;
  logic [W:0]         sra_wide;
  logic [W-1:0]       sc_result;
  logic               sc_carry;

  logic               div_zero;
  logic               iter_start;
  iter_mode_t         iter_mode;
  logic               iter_last;
  logic [W-1:0]       iter_result;
  logic               iter_carry;

  assign shamt = d2[SHAMT_W-1:0];

  // Shifts carry one guard bit so the last bit shifted out lands in a fixed
  // position; a zero shift leaves the guard bit at 0.
  always_comb begin
    add_sum  = {1'b0, d1} + {1'b0, d2};
    sub_sum  = {1'b0, d1} + {1'b0, ~d2} + (W+1)'(1);
    shl_wide = {1'b0, d1} << shamt;
    shr_wide = {d1, 1'b0} >> shamt;
    sra_wide = (W+1)'($signed({d1, 1'b0}) >>> shamt);
  end

  // Single-cycle result and carry for the op presented at the input
  always_comb begin
    sc_result = d1;
    sc_carry  = 1'b0;
    case (op)
      OP_ADD: begin
        sc_result = add_sum[W-1:0];
        sc_carry  = add_sum[W];
      end
      OP_SUB: begin
        sc_result = sub_sum[W-1:0];
        sc_carry  = sub_sum[W];
      end
      OP_OR:  sc_result = d1 | d2;
      OP_AND: sc_result = d1 & d2;
      OP_XOR: sc_result = d1 ^ d2;
`ifdef SEQ_ALU_DIV_EN
      // Only reached with a zero divisor; nonzero divisors iterate
      OP_DIV: begin
        sc_result = '1;
        sc_carry  = 1'b1;
      end
      OP_REM: begin
        sc_result = d1;
        sc_carry  = 1'b1;
      end
`endif
      OP_SHL: begin
        sc_result = shl_wide[W-1:0];
        sc_carry  = shl_wide[W];
      end
      OP_SHR: begin
        sc_result = shr_wide[W:1];
        sc_carry  = shr_wide[0];
      end
      OP_SRA: begin
        sc_result = sra_wide[W:1];
        sc_carry  = sra_wide[0];
      end
      default: begin
        sc_result = d1;
        sc_carry  = 1'b0;
      end
    endcase
  end

`ifdef SEQ_ALU_DIV_EN
  assign div_zero = ((op == OP_DIV) || (op == OP_REM)) && (d2 == '0);
`else
  assign div_zero = 1'b0;
`endif

  // Division by zero bypasses the iterative datapath entirely
  assign iter_start = (state_reg == ST_IDLE) && in_valid &&
                      is_multicycle(op) && !div_zero;

  // Map the opcode onto the iterative datapath's operation selector
  always_comb begin
    iter_mode = IT_MUL;
    if (op == OP_DIV) begin
      iter_mode = IT_DIV;
    end else if (op == OP_REM) begin
      iter_mode = IT_REM;
    end
  end

  seq_alu_iter #(
    .WORD_SIZE (WORD_SIZE)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (iter_start),
    .mode   (iter_mode),
    .a      (d1),
    .b      (d2),
    .last   (iter_last),
    .result (iter_result),
    .carry  (iter_carry)
  );

  // Handshake FSM; the output registers load only on entry to DONE so they
  // stay frozen while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      out_reg     <= '0;
      iszero_reg  <= 1'b0;
      iscarry_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            if (iter_start) begin
              state_reg <= ST_BUSY;
            end else begin
              state_reg   <= ST_DONE;
              out_reg     <= sc_result;
              iszero_reg  <= (sc_result == '0);
              iscarry_reg <= sc_carry;
            end
          end
        end
        ST_BUSY: begin
          if (iter_last) begin
            state_reg   <= ST_DONE;
            out_reg     <= iter_result;
            iszero_reg  <= (iter_result == '0);
            iscarry_reg <= iter_carry;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign out       = out_reg;
  assign iszero    = iszero_reg;
  assign iscarry   = iscarry_reg;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WORD_SIZE = 64. Expected values are
// hand-computed; DIV/REM expectations follow the SEQ_ALU_DIV_EN build.
module tb_seq_alu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] d1;
  logic [63:0] d2;
  logic [3:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] dout;
  logic        iszero;
  logic        iscarry;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

  seq_alu #(
    .WORD_SIZE (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d1        (d1),
    .d2        (d2),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .iszero    (iszero),
    .iscarry   (iscarry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Issue one op, scramble the inputs after accept, wait (bounded) for the
  // result and check latency, in_ready low time, result and flags.
  task automatic run_op(input string tag, input logic [3:0] o,
                        input logic [63:0] a, input logic [63:0] b,
                        input int exp_lat, input logic [63:0] exp_out,
                        input logic exp_z, input logic exp_c);
    int lat;
    int low;
    chk1({tag, "_inrdy"}, in_ready, 1'b1);
    op = o; d1 = a; d2 = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    op = 4'($urandom);
    lat = 1;
    low = in_ready ? 0 : 1;
    while (!out_valid && lat < 300) begin
      tick();
      lat++;
      if (!in_ready) low++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_lowcyc"}, 64'(low), 64'(exp_lat));
    chk({tag, "_out"}, dout, exp_out);
    chk1({tag, "_zero"}, iszero, exp_z);
    chk1({tag, "_carry"}, iscarry, exp_c);
    $display("op=%b a=%h b=%h -> out=%h z=%b c=%b lat=%0d", o, a, b, dout, iszero, iscarry, lat);
    if (out_ready) tick();
  endtask

  initial begin
    int ov;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    d1 = '0; d2 = '0; op = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out", dout, 64'd0);
    chk1("rst_zero", iszero, 1'b0);
    chk1("rst_carry", iscarry, 1'b0);
    chk1("rst_outvalid", out_valid, 1'b0);
    chk1("rst_inready", in_ready, 1'b1);

    run_op("add_6_7",   4'b0000, 64'd6, 64'd7, 1, 64'd13, 1'b0, 1'b0);
    run_op("add_wrap",  4'b0000, ONES, 64'd1, 1, 64'd0, 1'b1, 1'b1);
    run_op("sub_6_7",   4'b0001, 64'd6, 64'd7, 1, ONES, 1'b0, 1'b0);
    run_op("sub_7_6",   4'b0001, 64'd7, 64'd6, 1, 64'd1, 1'b0, 1'b1);
    run_op("mul_6_7",   4'b0010, 64'd6, 64'd7, 65, 64'd42, 1'b0, 1'b0);
    run_op("mul_ovf",   4'b0010, MSB, 64'd4, 65, 64'd0, 1'b1, 1'b1);
    run_op("shl_12_2",  4'b1001, 64'd12, 64'd2, 1, 64'd48, 1'b0, 1'b0);
    run_op("shl_msb",   4'b1001, MSB, 64'd65, 1, 64'd0, 1'b1, 1'b1);
    run_op("shr_12_2",  4'b1010, 64'd12, 64'd2, 1, 64'd3, 1'b0, 1'b0);
    run_op("shr_14_2",  4'b1010, 64'd14, 64'd2, 1, 64'd3, 1'b0, 1'b1);
    run_op("shr_0",     4'b1010, 64'd5, 64'd0, 1, 64'd5, 1'b0, 1'b0);
    run_op("sra_msb_4", 4'b1011, MSB, 64'd4, 1, 64'hF800_0000_0000_0000, 1'b0, 1'b0);
    run_op("or",        4'b0011, 64'd33, 64'd9, 1, 64'd41, 1'b0, 1'b0);
    run_op("and",       4'b0100, 64'hF0F0, 64'h0FF0, 1, 64'h00F0, 1'b0, 1'b0);
    run_op("xor",       4'b0101, 64'hA5A5, 64'hA5A5, 1, 64'd0, 1'b1, 1'b0);
    run_op("op1111",    4'b1111, 64'd33, 64'd9, 1, 64'd33, 1'b0, 1'b0);
`ifdef SEQ_ALU_DIV_EN
    run_op("div_100_7", 4'b0110, 64'd100, 64'd7, 65, 64'd14, 1'b0, 1'b0);
    run_op("rem_100_7", 4'b0111, 64'd100, 64'd7, 65, 64'd2, 1'b0, 1'b0);
    run_op("div_5_0",   4'b0110, 64'd5, 64'd0, 1, ONES, 1'b0, 1'b1);
    run_op("rem_5_0",   4'b0111, 64'd5, 64'd0, 1, 64'd5, 1'b0, 1'b1);
`else
    run_op("div_off",   4'b0110, 64'd100, 64'd7, 1, 64'd100, 1'b0, 1'b0);
    run_op("rem_off",   4'b0111, 64'd100, 64'd7, 1, 64'd100, 1'b0, 1'b0);
`endif

    // Backpressure: result held, no accept while DONE
    out_ready = 1'b0;
    run_op("mul_bp", 4'b0010, 64'd6, 64'd7, 65, 64'd42, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      op = 4'b0000; d1 = 64'd1; d2 = 64'd1; in_valid = 1'b1;
      tick();
      chk("bp_out", dout, 64'd42);
      chk1("bp_outvalid", out_valid, 1'b1);
      chk1("bp_inready", in_ready, 1'b0);
      $display("backpressure cycle %0d out=%h", i, dout);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk1("bp_release_ov", out_valid, 1'b0);
    chk1("bp_release_ir", in_ready, 1'b1);

    // Reset during BUSY aborts the multiply
    op = 4'b0010; d1 = 64'd3; d2 = 64'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk1("busy_inready", in_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("abort_outvalid", out_valid, 1'b0);
    chk("abort_out", dout, 64'd0);
    chk1("abort_inready", in_ready, 1'b1);
    chk1("abort_carry", iscarry, 1'b0);
    ov = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (out_valid) ov++;
    end
    chk("abort_no_result", 64'(ov), 64'd0);
    $display("reset during busy: out_valid seen %0d times", ov);
    run_op("add_after", 4'b0000, 64'd2, 64'd3, 1, 64'd5, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
